// File: rtl/score_bcd_keeper.sv
// score_bcd_keeper: three-digit BCD whack-a-mole score keeper with high-score tracking
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_game_start          pulse, starts or restarts a game (clears the score)
//   i_game_end            pulse, ends the current game
//   i_hit, i_miss         pulses, add HIT_PTS / subtract MISS_PTS while playing
//   o_bcd                 current score {hundreds, tens, units}
//   o_high_bcd            best completed-game score, same packing
//   o_new_record          one-cycle pulse when o_high_bcd is updated
//   o_saturated           score is 999
//   o_playing             FSM is in PLAY
module score_bcd_keeper #(
    parameter logic [3:0] HIT_PTS  = 4'd1,
    parameter logic [3:0] MISS_PTS = 4'd1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_game_start,
    input  logic        i_game_end,
    input  logic        i_hit,
    input  logic        i_miss,
    output logic [11:0] o_bcd,
    output logic [11:0] o_high_bcd,
    output logic        o_new_record,
    output logic        o_saturated,
    output logic        o_playing
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  r_state;
    logic [11:0] r_bcd;
    logic [11:0] r_high;
    logic        r_new_record;

    logic [3:0]  w_u, w_t, w_h;
    logic        w_uc, w_tc, w_hc;
    logic        w_ub, w_tb, w_hb;
    logic [11:0] w_inc, w_dec, w_next;

    // Carry/borrow is decided before the add/subtract so every digit stays in
    // 4-bit arithmetic and never leaves 0..9.
    always_comb begin
        w_u    = r_bcd[3:0];
        w_t    = r_bcd[7:4];
        w_h    = r_bcd[11:8];
        w_uc   = w_u >= 4'd10 - HIT_PTS;
        w_tc   = w_uc && w_t == 4'd9;
        w_hc   = w_tc && w_h == 4'd9;
        w_inc  = w_hc ? 12'h999 :
                 {w_h + {3'd0, w_tc},
                  w_tc ? 4'd0 : w_t + {3'd0, w_uc},
                  w_uc ? w_u - (4'd10 - HIT_PTS) : w_u + HIT_PTS};
        w_ub   = w_u < MISS_PTS;
        w_tb   = w_ub && w_t == 4'd0;
        w_hb   = w_tb && w_h == 4'd0;
        w_dec  = w_hb ? 12'h000 :
                 {w_h - {3'd0, w_tb},
                  w_tb ? 4'd9 : w_t - {3'd0, w_ub},
                  w_ub ? w_u + (4'd10 - MISS_PTS) : w_u - MISS_PTS};
        w_next = (i_hit && !i_miss) ? w_inc :
                 (i_miss && !i_hit) ? w_dec : r_bcd;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_bcd        <= 12'h000;
            r_high       <= 12'h000;
            r_new_record <= 1'b0;
        end else begin
            r_new_record <= 1'b0;
            case (r_state)
                IDLE: if (i_game_start) begin
                    r_state <= PLAY;
                    r_bcd   <= 12'h000;
                end
                PLAY: if (i_game_start) begin
                    r_bcd <= 12'h000;
                end else begin
                    r_bcd <= w_next;
                    if (i_game_end) r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                    // Valid BCD orders the same as plain binary.
                    if (r_bcd > r_high) begin
                        r_high       <= r_bcd;
                        r_new_record <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_bcd        = r_bcd;
    assign o_high_bcd   = r_high;
    assign o_new_record = r_new_record;
    assign o_saturated  = r_bcd == 12'h999;
    assign o_playing    = r_state == PLAY;
endmodule

// File: tb/tb_score_bcd_keeper.sv
// tb_score_bcd_keeper: directed and random-stream self-checking bench for score_bcd_keeper
module tb_score_bcd_keeper;
    logic        clk = 1'b0;
    logic        reset = 1'b1, gs = 1'b0, ge = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [11:0] bcd, high;
    logic        nr, sat, play;
    int          checks = 0, failures = 0;
    int          model;

    always #5 clk = ~clk;

    score_bcd_keeper dut (
        .i_clk(clk), .i_reset(reset), .i_game_start(gs), .i_game_end(ge),
        .i_hit(hit), .i_miss(miss), .o_bcd(bcd), .o_high_bcd(high),
        .o_new_record(nr), .o_saturated(sat), .o_playing(play)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic e, input logic h, input logic m, input logic r);
        {gs, ge, hit, miss, reset} = {s, e, h, m, r};
        @(posedge clk);
        #1;
        {gs, ge, hit, miss, reset} = 5'b0;
    endtask

    task automatic hits(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        #1;
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 1);
        chk("rst_bcd", bcd, 12'h000);
        chk("rst_high", high, 12'h000);
        chk("rst_nr", {11'd0, nr}, 12'd0);
        chk("rst_sat", {11'd0, sat}, 12'd0);
        chk("rst_play", {11'd0, play}, 12'd0);
        hits(1);
        chk("idle_hit", bcd, 12'h000);
        cyc(1, 0, 0, 0, 0);
        chk("start_play", {11'd0, play}, 12'd1);
        hits(12);
        chk("twelve_hits", bcd, 12'h012);
        chk("twelve_play", {11'd0, play}, 12'd1);
        cyc(1, 0, 0, 0, 0);
        hits(9);
        chk("to_009", bcd, 12'h009);
        hits(1);
        chk("carry_010", bcd, 12'h010);
        hits(89);
        chk("to_099", bcd, 12'h099);
        hits(1);
        chk("carry_100", bcd, 12'h100);
        cyc(0, 0, 0, 1, 0);
        chk("borrow_099", bcd, 12'h099);
        hits(899);
        chk("to_998", bcd, 12'h998);
        chk("sat_998", {11'd0, sat}, 12'd0);
        hits(1);
        chk("to_999", bcd, 12'h999);
        chk("sat_999", {11'd0, sat}, 12'd1);
        hits(1);
        chk("hold_999", bcd, 12'h999);
        cyc(0, 0, 0, 1, 0);
        chk("miss_999", bcd, 12'h998);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("floor_000", bcd, 12'h000);
        hits(50);
        cyc(0, 0, 1, 1, 0);
        chk("hit_miss_050", bcd, 12'h050);
        cyc(1, 0, 1, 0, 0);
        chk("start_beats_hit", bcd, 12'h000);
        hits(24);
        cyc(0, 1, 1, 0, 0);
        chk("end_hit_025", bcd, 12'h025);
        chk("done_play", {11'd0, play}, 12'd0);
        chk("done_nr", {11'd0, nr}, 12'd0);
        cyc(1, 0, 0, 0, 0);
        chk("rec_nr", {11'd0, nr}, 12'd1);
        chk("rec_high", high, 12'h025);
        chk("done_ignores_start", {11'd0, play}, 12'd0);
        cyc(0, 0, 0, 0, 0);
        chk("rec_nr_once", {11'd0, nr}, 12'd0);
        cyc(1, 0, 0, 0, 0);
        hits(25);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("eq_nr", {11'd0, nr}, 12'd0);
        chk("eq_high", high, 12'h025);
        cyc(1, 0, 0, 0, 0);
        hits(10);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("low_nr", {11'd0, nr}, 12'd0);
        chk("low_high", high, 12'h025);
        cyc(1, 0, 0, 0, 0);
        hits(5);
        cyc(1, 1, 0, 0, 0);
        chk("start_end_bcd", bcd, 12'h000);
        chk("start_end_play", {11'd0, play}, 12'd1);
        chk("start_end_high", high, 12'h025);
        hits(40);
        cyc(1, 0, 0, 0, 0);
        chk("restart_bcd", bcd, 12'h000);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("restart_nr", {11'd0, nr}, 12'd0);
        chk("restart_high", high, 12'h025);
        cyc(1, 0, 0, 0, 0);
        hits(31);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rec30_high", high, 12'h031);
        cyc(1, 0, 0, 0, 0);
        hits(30);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rec30_nr", {11'd0, nr}, 12'd0);
        chk("rec30_keep", high, 12'h031);
        cyc(1, 0, 0, 0, 0);
        hits(77);
        chk("pre_rst_077", bcd, 12'h077);
        cyc(0, 1, 0, 0, 1);
        chk("mid_rst_bcd", bcd, 12'h000);
        chk("mid_rst_high", high, 12'h000);
        chk("mid_rst_play", {11'd0, play}, 12'd0);
        cyc(0, 0, 0, 0, 0);
        chk("mid_rst_nr", {11'd0, nr}, 12'd0);
        cyc(1, 0, 0, 0, 0);
        model = 0;
        for (int i = 0; i < 600; i++) begin
            logic h, m;
            h = $urandom_range(0, 99) < 55;
            m = $urandom_range(0, 99) < 40;
            cyc(0, 0, h, m, 0);
            if (h && !m) model = (model < 999) ? model + 1 : 999;
            if (m && !h) model = (model > 0) ? model - 1 : 0;
            chk("rand_stream", bcd, to_bcd(model));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
